// File: rtl/vga_pkg.sv
// vga_pkg: shared definitions for the VGA timing blocks.
//   - 640x480@60 timing constants (pixel ticks / lines)
//   - sync polarity constants
//   - width_of(): bits needed to hold 0..n-1 (never less than 1)
package vga_pkg;

  localparam bit ACTIVE_LOW  = 1'b0;
  localparam bit ACTIVE_HIGH = 1'b1;

  localparam int VGA_CLK_DIV  = 2;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 29;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_PIX_W    = 8;

  // Counter width for a range of n values; a 1-value range still needs a
  // real signal, hence the floor of one bit.
  function automatic int width_of(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/vga_pix_tick.sv
// vga_pix_tick: pixel-clock enable generator.
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   en     in  run enable; low clears the divider
//   tick   out high for one clk every CLK_DIV clks (every clk when CLK_DIV=1)
module vga_pix_tick
  import vga_pkg::*;
#(
  parameter int CLK_DIV = VGA_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int              DW       = width_of(CLK_DIV);
  localparam logic [DW-1:0]   DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
    end else if (!en) begin
      div <= '0;
    end else if (div == DIV_LAST) begin
      div <= '0;
    end else begin
      div <= div + DW'(1);
    end
  end

  // Gated by en so a stale divider value can never produce a tick while idle.
  assign tick = en && (div == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
//   clk          in  system clock
//   rst_n        in  asynchronous active-low reset
//   en           in  run enable; low idles the generator (synchronous clear)
//   pixel_in     in  colour for the coordinate requested on the previous tick
//   pix_req      out (x, y) is in the active area; pixel_in wanted next tick
//   x, y         out active-area coordinate of the current request
//   o_pixel      out blanked colour to the DAC
//   hs, vs, de   out registered syncs and data enable
//   frame_start  out one-clk strobe when (0,0) reaches the output stage
//   line_start   out one-clk strobe when column 0 reaches the output stage
//
// Pixel handshake: pix_req/x/y are combinational from the counter stage and
// hold for a full pixel tick. There is no back-pressure: whenever pix_req is
// high, the source must present pixel_in for (x, y) before the next tick,
// where it is captured into o_pixel together with de.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = VGA_CLK_DIV,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter bit HS_POL   = ACTIVE_LOW,
  parameter bit VS_POL   = ACTIVE_LOW,
  parameter int PIX_W    = VGA_PIX_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [PIX_W-1:0]              pixel_in,
  output logic                          pix_req,
  output logic [width_of(H_ACTIVE)-1:0] x,
  output logic [width_of(V_ACTIVE)-1:0] y,
  output logic [PIX_W-1:0]              o_pixel,
  output logic                          hs,
  output logic                          vs,
  output logic                          de,
  output logic                          frame_start,
  output logic                          line_start
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int HW      = width_of(H_TOTAL);
  localparam int VW      = width_of(V_TOTAL);
  localparam int XW      = width_of(H_ACTIVE);
  localparam int YW      = width_of(V_ACTIVE);

  // Region boundaries. With every region non-empty, *_END < *_TOTAL, so
  // all of these fit in the counter width.
  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SYNCE = HW'(H_SYNC);
  localparam logic [HW-1:0] H_START = HW'(H_SYNC + H_BP);
  localparam logic [HW-1:0] H_END   = HW'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_SYNCE = VW'(V_SYNC);
  localparam logic [VW-1:0] V_START = VW'(V_SYNC + V_BP);
  localparam logic [VW-1:0] V_END   = VW'(V_SYNC + V_BP + V_ACTIVE);

  localparam bit PARAMS_OK = (CLK_DIV > 0) && (H_SYNC > 0) && (H_BP > 0) &&
                             (H_ACTIVE > 0) && (H_FP > 0) && (V_SYNC > 0) &&
                             (V_BP > 0) && (V_ACTIVE > 0) && (V_FP > 0) &&
                             (PIX_W > 0);

  param_ok_a: assert property (@(posedge clk) PARAMS_OK)
    else $error("vga_timing_gen: every timing parameter must be > 0");

  logic tick;

  vga_pix_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .tick  (tick)
  );

  // ---------------- stage 0: raster counters ----------------
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (!en) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (tick) begin
      if (hcnt == H_LAST) begin
        hcnt <= '0;
        vcnt <= (vcnt == V_LAST) ? '0 : vcnt + VW'(1);
      end else begin
        hcnt <= hcnt + HW'(1);
      end
    end
  end

  logic h_act;
  logic v_act;

  // Half-open active windows: column/line *_END is already porch.
  assign h_act   = (hcnt >= H_START) && (hcnt < H_END);
  assign v_act   = (vcnt >= V_START) && (vcnt < V_END);
  assign pix_req = h_act && v_act;
  assign x       = h_act ? XW'(hcnt - H_START) : '0;
  assign y       = v_act ? YW'(vcnt - V_START) : '0;

  // ---------------- stage 1: registered outputs ----------------
  logic hs_next;
  logic vs_next;

  assign hs_next = (hcnt < H_SYNCE) ? HS_POL : !HS_POL;
  assign vs_next = (vcnt < V_SYNCE) ? VS_POL : !VS_POL;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs          <= !HS_POL;
      vs          <= !VS_POL;
      de          <= 1'b0;
      o_pixel     <= '0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else if (!en) begin
      hs          <= !HS_POL;
      vs          <= !VS_POL;
      de          <= 1'b0;
      o_pixel     <= '0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else begin
      // Strobes last exactly one clk even when a tick spans CLK_DIV clks.
      frame_start <= 1'b0;
      line_start  <= 1'b0;
      if (tick) begin
        hs          <= hs_next;
        vs          <= vs_next;
        de          <= pix_req;
        o_pixel     <= pix_req ? pixel_in : '0;
        line_start  <= (hcnt == '0);
        frame_start <= (hcnt == '0) && (vcnt == '0);
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: three instances of vga_timing_gen sharing clk/rst_n/en.
//   A: default 640x480 timing
//   B: default horizontal timing, 5-line frame (full frame fits the run)
//   C: CLK_DIV=1, 7x5 raster, active-high hs
// A raster model (position = ticks elapsed, decoded with plain arithmetic)
// is checked against all outputs every clk, plus hand-computed literals.
module tb_vga_timing_gen;
  import vga_pkg::*;

  typedef struct {
    int div, hs, hbp, ha, hfp, vs, vbp, va, vfp;
    bit hpol, vpol;
  } cfg_t;

  typedef struct {
    bit pix_req; int x; int y;
    bit hs; bit vs; bit de; bit fs; bit ls; int pix;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic clk_run = 1'b1;
  logic rst_n = 1'b0;
  logic en = 1'b0;

  initial forever begin
    #5;
    if (clk_run) clk = ~clk;
  end

  int cyc = 0;   // clk edges seen with rst_n and en high since last idle
  int n_cmp = 0;
  int n_bad = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cyc <= 0;
    else if (!en) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  // ---------------- DUTs ----------------
  logic [7:0] pixel_in_a = '0, pixel_in_b = '0, pixel_in_c = '0;
  logic       pix_req_a, pix_req_b, pix_req_c;
  logic [9:0] x_a, x_b;
  logic [1:0] x_c;
  logic [8:0] y_a;
  logic [0:0] y_b, y_c;
  logic [7:0] o_pixel_a, o_pixel_b, o_pixel_c;
  logic       hs_a, hs_b, hs_c, vs_a, vs_b, vs_c, de_a, de_b, de_c;
  logic       fs_a, fs_b, fs_c, ls_a, ls_b, ls_c;

  vga_timing_gen u_dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .pixel_in(pixel_in_a),
    .pix_req(pix_req_a), .x(x_a), .y(y_a), .o_pixel(o_pixel_a),
    .hs(hs_a), .vs(vs_a), .de(de_a), .frame_start(fs_a), .line_start(ls_a)
  );

  vga_timing_gen #(
    .V_SYNC(1), .V_BP(1), .V_ACTIVE(2), .V_FP(1)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .pixel_in(pixel_in_b),
    .pix_req(pix_req_b), .x(x_b), .y(y_b), .o_pixel(o_pixel_b),
    .hs(hs_b), .vs(vs_b), .de(de_b), .frame_start(fs_b), .line_start(ls_b)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_SYNC(1), .H_BP(1), .H_ACTIVE(4), .H_FP(1),
    .V_SYNC(1), .V_BP(1), .V_ACTIVE(2), .V_FP(1), .HS_POL(ACTIVE_HIGH)
  ) u_dut_c (
    .clk(clk), .rst_n(rst_n), .en(en), .pixel_in(pixel_in_c),
    .pix_req(pix_req_c), .x(x_c), .y(y_c), .o_pixel(o_pixel_c),
    .hs(hs_c), .vs(vs_c), .de(de_c), .frame_start(fs_c), .line_start(ls_c)
  );

  // ---------------- model ----------------
  function automatic cfg_t get_cfg(input int id);
    cfg_t c;
    case (id)
      0:       c = '{2, 96, 48, 640, 16, 2, 29, 480, 10, 1'b0, 1'b0};
      1:       c = '{2, 96, 48, 640, 16, 1, 1, 2, 1, 1'b0, 1'b0};
      default: c = '{1, 1, 1, 4, 1, 1, 1, 2, 1, 1'b1, 1'b0};
    endcase
    return c;
  endfunction

  // Pixel source: A/B send the column, C tags row/column with bit 7 so
  // blanking of a non-zero input is visible.
  function automatic logic [7:0] pix_src(input int id, input int px, input int py);
    logic [7:0] v;
    if (id == 2) v = 8'(8'h80 | (py << 2) | px);
    else         v = 8'(px);
    return v;
  endfunction

  function automatic exp_t model(input int id, input int c_cyc);
    cfg_t c;
    exp_t e;
    int ht, vt, hst, vst, t, h, v, p;
    bit hin, vin;
    c   = get_cfg(id);
    ht  = c.hs + c.hbp + c.ha + c.hfp;
    vt  = c.vs + c.vbp + c.va + c.vfp;
    hst = c.hs + c.hbp;
    vst = c.vs + c.vbp;
    t   = c_cyc / c.div;
    // request side: raster position = ticks elapsed
    h = t % ht;
    v = (t / ht) % vt;
    hin = (h >= hst) && (h < hst + c.ha);
    vin = (v >= vst) && (v < vst + c.va);
    e.pix_req = hin && vin;
    e.x = hin ? h - hst : 0;
    e.y = vin ? v - vst : 0;
    // output side: one tick behind
    if (t == 0) begin
      e.hs = !c.hpol; e.vs = !c.vpol; e.de = 0; e.pix = 0; e.fs = 0; e.ls = 0;
    end else begin
      p = t - 1;
      h = p % ht;
      v = (p / ht) % vt;
      hin = (h >= hst) && (h < hst + c.ha);
      vin = (v >= vst) && (v < vst + c.va);
      e.hs  = (h < c.hs) ? c.hpol : !c.hpol;
      e.vs  = (v < c.vs) ? c.vpol : !c.vpol;
      e.de  = hin && vin;
      e.pix = e.de ? int'(pix_src(id, h - hst, v - vst)) : 0;
      e.ls  = ((c_cyc % c.div) == 0) && (h == 0);
      e.fs  = e.ls && (v == 0);
    end
    return e;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s cyc=%0d t=%0t got=%0d want=%0d", nm, cyc, $time, act, exp);
    end
  endtask

  task automatic check_dut(input int id, input bit pr, input int xx, input int yy,
                           input bit h, input bit v, input bit d, input bit f,
                           input bit l, input int px);
    exp_t e;
    string s;
    e = model(id, cyc);
    s = (id == 0) ? "A" : (id == 1) ? "B" : "C";
    chk({s, ".pix_req"}, pr, e.pix_req);
    chk({s, ".x"}, xx, e.x);
    chk({s, ".y"}, yy, e.y);
    chk({s, ".hs"}, h, e.hs);
    chk({s, ".vs"}, v, e.vs);
    chk({s, ".de"}, d, e.de);
    chk({s, ".frame_start"}, f, e.fs);
    chk({s, ".line_start"}, l, e.ls);
    chk({s, ".o_pixel"}, px, e.pix);
  endtask

  always @(negedge clk) begin
    check_dut(0, pix_req_a, int'(x_a), int'(y_a), hs_a, vs_a, de_a, fs_a, ls_a, int'(o_pixel_a));
    check_dut(1, pix_req_b, int'(x_b), int'(y_b), hs_b, vs_b, de_b, fs_b, ls_b, int'(o_pixel_b));
    check_dut(2, pix_req_c, int'(x_c), int'(y_c), hs_c, vs_c, de_c, fs_c, ls_c, int'(o_pixel_c));
  end

  // ---------------- pixel source driver ----------------
  always @(negedge clk) begin
    pixel_in_a = pix_src(0, int'(x_a), int'(y_a));
    pixel_in_b = pix_src(1, int'(x_b), int'(y_b));
    pixel_in_c = pix_src(2, int'(x_c), int'(y_c));
  end

  task automatic report();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not complete, time=%0t", $time);
    n_bad++;
    report();
    $finish;
  end

  // ---------------- directed sequence ----------------
  initial begin
    int first_hs_a, hs_low0, hs_low1, vs_low_a, run_len, max_x_b;
    int pix_before_fall, pix_at_fall, hs_c_hi, preq_c, prev_pix_b;
    int fs_a_first, fs_c_first, found;
    bit prev_de_b;
    int ls_a_t[$], fs_b_t[$], ls_c_t[$], fs_c_t[$], de_runs[$];

    first_hs_a = -1; hs_low0 = 0; hs_low1 = 0; vs_low_a = 0; run_len = 0;
    max_x_b = 0; pix_before_fall = -1; pix_at_fall = -1; hs_c_hi = 0;
    preq_c = 0; prev_pix_b = 0; prev_de_b = 0;

    repeat (3) @(negedge clk);
    chk("rst.hs_a", hs_a, 1);
    chk("rst.hs_c", hs_c, 0);
    chk("rst.o_pixel_c", o_pixel_c, 0);
    rst_n = 1'b1;
    en    = 1'b1;

    for (int i = 0; i < 8100; i++) begin
      @(negedge clk);
      if (first_hs_a < 0 && !hs_a) first_hs_a = cyc;
      if (cyc <= 1600) begin
        if (!hs_a) hs_low0++;
      end else if (cyc <= 3200) begin
        if (!hs_a) hs_low1++;
      end
      if (cyc <= 3300 && !vs_a) vs_low_a++;
      if (ls_a) ls_a_t.push_back(cyc);
      if (fs_b) fs_b_t.push_back(cyc);
      if (de_b) run_len++;
      else if (prev_de_b) begin
        de_runs.push_back(run_len);
        run_len = 0;
        if (pix_at_fall < 0) begin
          pix_before_fall = prev_pix_b;
          pix_at_fall     = int'(o_pixel_b);
        end
      end
      prev_de_b  = de_b;
      prev_pix_b = int'(o_pixel_b);
      if (pix_req_b && int'(x_b) > max_x_b) max_x_b = int'(x_b);
      if (cyc <= 35) begin
        if (hs_c) hs_c_hi++;
        if (pix_req_c) preq_c++;
      end
      if (ls_c) ls_c_t.push_back(cyc);
      if (fs_c) fs_c_t.push_back(cyc);
    end

    chk("A.first_hs_fall_cyc", first_hs_a, 2);
    chk("A.hs_low_line0", hs_low0, 192);
    chk("A.hs_low_line1", hs_low1, 192);
    chk("A.vs_low_clks", vs_low_a, 3200);
    chk("A.line_start_count", ls_a_t.size() >= 2 ? 1 : 0, 1);
    if (ls_a_t.size() >= 2) chk("A.line_start_period", ls_a_t[1] - ls_a_t[0], 1600);
    chk("B.de_runs", de_runs.size(), 2);
    foreach (de_runs[i]) chk("B.de_run_len", de_runs[i], 1280);
    chk("B.pixel_x639", pix_before_fall, 127);
    chk("B.pixel_after_last", pix_at_fall, 0);
    chk("B.max_x", max_x_b, 639);
    chk("B.frame_start_count", fs_b_t.size() >= 2 ? 1 : 0, 1);
    if (fs_b_t.size() >= 2) chk("B.frame_period", fs_b_t[1] - fs_b_t[0], 8000);
    chk("C.hs_high_per_frame", hs_c_hi, 5);
    chk("C.pix_req_per_frame", preq_c, 8);
    chk("C.strobe_count", (ls_c_t.size() >= 2 && fs_c_t.size() >= 2) ? 1 : 0, 1);
    if (ls_c_t.size() >= 2) chk("C.line_period", ls_c_t[1] - ls_c_t[0], 7);
    if (fs_c_t.size() >= 2) chk("C.frame_period", fs_c_t[1] - fs_c_t[0], 35);

    // en low mid-frame for 10 clk
    en = 1'b0;
    repeat (10) @(negedge clk);
    chk("idle.hs_c", hs_c, 0);
    chk("idle.de_b", de_b, 0);
    en = 1'b1;
    fs_a_first = -1; fs_c_first = -1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (fs_a && fs_a_first < 0) fs_a_first = cyc;
      if (fs_c && fs_c_first < 0) fs_c_first = cyc;
    end
    chk("A.restart_frame_start", fs_a_first, 2);
    chk("C.restart_frame_start", fs_c_first, 1);

    // reach B's active video, then reset with the clock stopped
    found = 0;
    for (int i = 0; i < 5000 && found == 0; i++) begin
      @(negedge clk);
      if (de_b) found = 1;
    end
    chk("B.reach_active", found, 1);
    clk_run = 1'b0;
    #20;
    chk("pre_rst.pix_req_b", pix_req_b, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst.hs_a", hs_a, 1);
    chk("async_rst.vs_a", vs_a, 1);
    chk("async_rst.de_b", de_b, 0);
    chk("async_rst.o_pixel_b", o_pixel_b, 0);
    chk("async_rst.pix_req_b", pix_req_b, 0);
    chk("async_rst.x_b", x_b, 0);
    chk("async_rst.hs_c", hs_c, 0);
    chk("async_rst.o_pixel_c", o_pixel_c, 0);
    chk("async_rst.strobes", {fs_a, ls_a, fs_b, ls_b, fs_c, ls_c}, 0);
    #5;
    rst_n = 1'b1;
    #3;
    clk_run = 1'b1;
    repeat (200) @(negedge clk);

    report();
    $finish;
  end

endmodule
